draw_cmd_decoder: RTL and testbench

Command front end for line_drawing_engine. Takes the 32-bit host command stream and assembles LINE, POLYLINE and RECT commands. Expands each command into one or more 52-bit line ops {x1,y1,x2,y2,color} and drives them into the engine's input FIFO through an rts/rtr handshake. All geometry expansion and coordinate clamping happen here.

---
 rtl/draw_cmd_decoder_if.sv | 22 ++
 rtl/draw_cmd_decoder.sv | 196 +++++++++++++++++++
 tb/tb_draw_cmd_decoder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/draw_cmd_decoder_if.sv
// Handshake bundle between host, command decoder and line engine FIFO.
// The slave side is the decoder; the master side drives host words and consumes line ops.
interface draw_cmd_decoder_if;
   logic [31:0] in_data;
   logic        in_rts;
   logic        in_rtr;
   logic [51:0] out_op;
   logic        out_rts;
   logic        out_rtr;
   logic        err;
   logic        busy;

   modport slave (
      input  in_data, in_rts, out_rtr,
      output in_rtr, out_op, out_rts, err, busy
   );

   modport master (
      output in_data, in_rts, out_rtr,
      input  in_rtr, out_op, out_rts, err, busy
   );
endinterface

// File: rtl/draw_cmd_decoder.sv
// Assembles LINE / POLYLINE / RECT host commands and expands them into
// clamped 52-bit line ops {x1,y1,x2,y2,color} for the line engine.
module draw_cmd_decoder #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input logic               clk,
   input logic               rst,
   draw_cmd_decoder_if.slave bus
);
   typedef enum logic [1:0] {HDR, VTX, RECT_EMIT, DROP} state_e;

   localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
   localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

   state_e      state_q, state_d;
   logic [11:0] color_q, color_d;
   logic        is_rect_q, is_rect_d;
   logic        close_q, close_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        have_first_q, have_first_d;
   logic [9:0]  first_x_q, first_x_d, first_y_q, first_y_d;
   logic [9:0]  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
   logic [1:0]  pend_q, pend_d;
   logic [51:0] out_op_q, out_op_d;
   logic        out_rts_q, out_rts_d;
   logic        err_q, err_d;

   logic        load_ok, in_rtr_c, acc;
   logic [9:0]  vx, vy;
   logic        unused_bits;

   function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign unused_bits = ^bus.in_data[15:10];
   assign load_ok     = !out_rts_q || bus.out_rtr;
   assign vx          = clamp(bus.in_data[25:16], X_MAX);
   assign vy          = clamp(bus.in_data[9:0], Y_MAX);
   assign acc         = bus.in_rts && in_rtr_c;

   always_comb begin
      in_rtr_c = 1'b0;
      case (state_q)
         HDR:       in_rtr_c = 1'b1;
         VTX:       in_rtr_c = load_ok;
         RECT_EMIT: in_rtr_c = 1'b0;
         DROP:      in_rtr_c = 1'b1;
         default:   in_rtr_c = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      color_d      = color_q;
      is_rect_d    = is_rect_q;
      close_d      = close_q;
      cnt_d        = cnt_q;
      have_first_d = have_first_q;
      first_x_d    = first_x_q;
      first_y_d    = first_y_q;
      prev_x_d     = prev_x_q;
      prev_y_d     = prev_y_q;
      pend_d       = pend_q;
      out_op_d     = out_op_q;
      out_rts_d    = out_rts_q && !bus.out_rtr;
      err_d        = err_q;

      case (state_q)
         HDR: begin
            if (acc) begin
               color_d      = bus.in_data[27:16];
               have_first_d = 1'b0;
               is_rect_d    = 1'b0;
               close_d      = 1'b0;
               case (bus.in_data[31:28])
                  4'd1: begin
                     cnt_d   = 8'd2;
                     state_d = VTX;
                  end
                  4'd2: begin
                     cnt_d   = bus.in_data[7:0];
                     close_d = bus.in_data[8] && (bus.in_data[7:0] >= 8'd3);
                     if (bus.in_data[7:0] >= 8'd2)
                        state_d = VTX;
                     else if (bus.in_data[7:0] == 8'd1)
                        state_d = DROP;
                  end
                  4'd3: begin
                     is_rect_d = 1'b1;
                     cnt_d     = 8'd2;
                     state_d   = VTX;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         VTX: begin
            if (acc) begin
               cnt_d    = cnt_q - 8'd1;
               prev_x_d = vx;
               prev_y_d = vy;
               if (!have_first_q) begin
                  have_first_d = 1'b1;
                  first_x_d    = vx;
                  first_y_d    = vy;
               end else begin
                  // A rectangle's first edge is horizontal: keep corner A's y.
                  if (is_rect_q)
                     out_op_d = {prev_x_q, prev_y_q, vx, prev_y_q, color_q};
                  else
                     out_op_d = {prev_x_q, prev_y_q, vx, vy, color_q};
                  out_rts_d = 1'b1;
                  if (cnt_q == 8'd1) begin
                     if (is_rect_q) begin
                        pend_d  = 2'd3;
                        state_d = RECT_EMIT;
                     end else if (close_q) begin
                        pend_d  = 2'd1;
                        state_d = RECT_EMIT;
                     end else begin
                        state_d = HDR;
                     end
                  end
               end
            end
         end
         RECT_EMIT: begin
            if (load_ok) begin
               out_rts_d = 1'b1;
               pend_d    = pend_q - 2'd1;
               // prev holds corner B / last vertex, first holds corner A / first vertex.
               if (!is_rect_q)
                  out_op_d = {prev_x_q, prev_y_q, first_x_q, first_y_q, color_q};
               else if (pend_q == 2'd3)
                  out_op_d = {prev_x_q, first_y_q, prev_x_q, prev_y_q, color_q};
               else if (pend_q == 2'd2)
                  out_op_d = {prev_x_q, prev_y_q, first_x_q, prev_y_q, color_q};
               else
                  out_op_d = {first_x_q, prev_y_q, first_x_q, first_y_q, color_q};
               if (pend_q == 2'd1)
                  state_d = HDR;
            end
         end
         DROP: begin
            if (acc) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1)
                  state_d = HDR;
            end
         end
         default: state_d = HDR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HDR;
         color_q      <= '0;
         is_rect_q    <= 1'b0;
         close_q      <= 1'b0;
         cnt_q        <= '0;
         have_first_q <= 1'b0;
         first_x_q    <= '0;
         first_y_q    <= '0;
         prev_x_q     <= '0;
         prev_y_q     <= '0;
         pend_q       <= '0;
         out_op_q     <= '0;
         out_rts_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         color_q      <= color_d;
         is_rect_q    <= is_rect_d;
         close_q      <= close_d;
         cnt_q        <= cnt_d;
         have_first_q <= have_first_d;
         first_x_q    <= first_x_d;
         first_y_q    <= first_y_d;
         prev_x_q     <= prev_x_d;
         prev_y_q     <= prev_y_d;
         pend_q       <= pend_d;
         out_op_q     <= out_op_d;
         out_rts_q    <= out_rts_d;
         err_q        <= err_d;
      end
   end

   assign bus.in_rtr  = in_rtr_c;
   assign bus.out_op  = out_op_q;
   assign bus.out_rts = out_rts_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != HDR) || out_rts_q;
endmodule

// File: tb/tb_draw_cmd_decoder.sv
// Directed bench for draw_cmd_decoder: hand-computed line ops checked by
// immediate assertions, one line per transaction.
module tb_draw_cmd_decoder;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [51:0] got_q[$];
   logic [51:0] rect_exp[4];

   draw_cmd_decoder_if bus ();

   draw_cmd_decoder #(.SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [51:0] mkop(input int x1, input int y1, input int x2,
                                        input int y2, input int c);
      return {10'(x1), 10'(y1), 10'(x2), 10'(y2), 12'(c)};
   endfunction

   function automatic logic [31:0] vtx(input int x, input int y);
      return {6'b0, 10'(x), 6'b0, 10'(y)};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Captures every completed output transfer, sampled mid-cycle.
   always @(negedge clk) begin
      #2;
      if (!rst && bus.out_rts && bus.out_rtr) begin
         got_q.push_back(bus.out_op);
         $display("op  x1=%0d y1=%0d x2=%0d y2=%0d color=%h", bus.out_op[51:42],
                  bus.out_op[41:32], bus.out_op[31:22], bus.out_op[21:12], bus.out_op[11:0]);
      end
   end

   task automatic send(input logic [31:0] w);
      int k;
      @(negedge clk);
      bus.in_data = w;
      bus.in_rts  = 1'b1;
      k = 0;
      while (!bus.in_rtr && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      assert (k < 100)
      else begin
         n_fail++;
         $error("FAIL send_timeout observed=%0d expected=<100 word=%h", k, w);
      end
      @(posedge clk);
      #1 bus.in_rts = 1'b0;
      $display("in  word=%h", w);
   endtask

   task automatic wait_ops(input string tag, input int n);
      int k;
      k = 0;
      while (got_q.size() < n && k < 40) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check({tag, "_count"}, 64'(got_q.size()), 64'(n));
   endtask

   task automatic pop_check(input string tag, input logic [51:0] exp);
      logic [51:0] v;
      v = '0;
      if (got_q.size() > 0) v = got_q.pop_front();
      check(tag, 64'(v), 64'(exp));
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.in_data = '0;
      bus.in_rts  = 1'b0;
      bus.out_rtr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_rts", 64'(bus.out_rts), 64'(0));
      check("rst_out_op", 64'(bus.out_op), 64'(0));
      check("rst_err", 64'(bus.err), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_rtr", 64'(bus.in_rtr), 64'(1));

      // LINE with one-cycle latency
      bus.out_rtr = 1'b1;
      send(32'h1ABC_0000);
      send(vtx(10, 20));
      send(vtx(300, 200));
      check("line_rts_latency", 64'(bus.out_rts), 64'(1));
      check("line_op_latency", 64'(bus.out_op), 64'(mkop(10, 20, 300, 200, 12'hABC)));
      wait_ops("line", 1);
      pop_check("line_op", mkop(10, 20, 300, 200, 12'hABC));
      check("line_idle", 64'(bus.busy), 64'(0));

      // closed POLYLINE, N=3
      send(32'h20F0_0103);
      send(vtx(0, 0));
      send(vtx(100, 0));
      send(vtx(100, 50));
      wait_ops("poly", 3);
      pop_check("poly_op0", mkop(0, 0, 100, 0, 12'h0F0));
      pop_check("poly_op1", mkop(100, 0, 100, 50, 12'h0F0));
      pop_check("poly_op2", mkop(100, 50, 0, 0, 12'h0F0));

      // RECT with 3-cycle stalls per op
      rect_exp[0] = mkop(5, 5, 20, 5, 12'hF00);
      rect_exp[1] = mkop(20, 5, 20, 30, 12'hF00);
      rect_exp[2] = mkop(20, 30, 5, 30, 12'hF00);
      rect_exp[3] = mkop(5, 30, 5, 5, 12'hF00);
      @(negedge clk);
      bus.out_rtr = 1'b0;
      send(32'h3F00_0000);
      send(vtx(5, 5));
      send(vtx(20, 30));
      for (int i = 0; i < 4; i++) begin
         repeat (3) begin
            @(negedge clk);
            #2;
            check($sformatf("rect_stall_rts%0d", i), 64'(bus.out_rts), 64'(1));
            check($sformatf("rect_stall_op%0d", i), 64'(bus.out_op), 64'(rect_exp[i]));
            check($sformatf("rect_in_rtr%0d", i), 64'(bus.in_rtr), 64'((i < 3) ? 0 : 1));
         end
         @(negedge clk);
         bus.out_rtr = 1'b1;
         @(posedge clk);
         #1 bus.out_rtr = 1'b0;
      end
      wait_ops("rect", 4);
      for (int i = 0; i < 4; i++) pop_check($sformatf("rect_op%0d", i), rect_exp[i]);
      check("rect_idle", 64'(bus.busy), 64'(0));

      // clamping at and beyond the screen edge
      @(negedge clk);
      bus.out_rtr = 1'b1;
      send(32'h1123_0000);
      send(vtx(700, 1023));
      send(vtx(639, 479));
      send(32'h1123_0000);
      send(vtx(640, 480));
      send(vtx(638, 478));
      wait_ops("clamp", 2);
      pop_check("clamp_op0", mkop(639, 479, 639, 479, 12'h123));
      pop_check("clamp_op1", mkop(639, 479, 638, 478, 12'h123));

      // illegal opcode, then LINE; POLYLINE N=1 and N=0 emit nothing
      send(32'h7000_0000);
      @(negedge clk);
      check("err_set", 64'(bus.err), 64'(1));
      send(32'h1555_0000);
      send(vtx(1, 2));
      send(vtx(3, 4));
      wait_ops("after_err", 1);
      pop_check("after_err_op", mkop(1, 2, 3, 4, 12'h555));
      check("err_sticky", 64'(bus.err), 64'(1));
      send(32'h2000_0001);
      send(32'hFFFF_FFFF);
      @(negedge clk);
      check("drop_idle", 64'(bus.busy), 64'(0));
      send(32'h2000_0000);
      @(negedge clk);
      check("n0_idle", 64'(bus.busy), 64'(0));
      wait_ops("drop", 0);

      // reset in the middle of RECT_EMIT with a stalled op
      @(negedge clk);
      bus.out_rtr = 1'b0;
      send(32'h3F00_0000);
      send(vtx(5, 5));
      send(vtx(20, 30));
      @(negedge clk);
      check("pre_rst_rts", 64'(bus.out_rts), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_rts", 64'(bus.out_rts), 64'(0));
      check("mid_rst_busy", 64'(bus.busy), 64'(0));
      check("mid_rst_err", 64'(bus.err), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_in_rtr", 64'(bus.in_rtr), 64'(1));
      bus.out_rtr = 1'b1;
      send(32'h1777_0000);
      send(vtx(7, 8));
      send(vtx(9, 10));
      wait_ops("post_rst", 1);
      pop_check("post_rst_op", mkop(7, 8, 9, 10, 12'h777));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
